// File: rtl/ibram_port_arbiter_pkg.sv
// Shared types and configuration for the ibram port arbiter.
// Build option: IBRAM_ARB_STARVE_GUARD_EN enables the starvation guard.
package taiga_config;
    localparam int IBRAM_STARVE_LIMIT = 8;
endpackage

package taiga_types;
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_SEC   = 2'd2
    } ibram_owner_t;
endpackage

// File: rtl/ibram_port_arbiter_starve_counter.sv
// Saturating wait counter for the secondary requester plus its force flag.
// Only instantiated when IBRAM_ARB_STARVE_GUARD_EN is defined.
module ibram_starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic sec_req_i,
    input  logic sec_gnt_i,
    output logic force_o
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!sec_req_i || sec_gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIM) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = sec_req_i & (cnt_q == LIM);
endmodule

// File: rtl/ibram_port_arbiter.sv
// Shares the ibram port between fetch (priority) and a secondary requester.
// Build option: IBRAM_ARB_STARVE_GUARD_EN adds a forced secondary slot.
module ibram_port_arbiter
    import taiga_types::*;
#(
    parameter int ADDR_W       = 14,
    parameter int STARVE_LIMIT = taiga_config::IBRAM_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_flush,
    output logic              fetch_ready,
    output logic              fetch_data_valid,
    output logic [31:0]       fetch_data,
    input  logic              sec_req,
    input  logic              sec_we,
    input  logic [ADDR_W-1:0] sec_addr,
    input  logic [3:0]        sec_be,
    input  logic [31:0]       sec_wdata,
    output logic              sec_gnt,
    output logic              sec_rvalid,
    output logic [31:0]       sec_rdata,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [3:0]        bram_be,
    output logic [31:0]       bram_data_in,
    input  logic [31:0]       bram_data_out
);
    ibram_owner_t owner_q;
    ibram_owner_t owner_d;
    logic         kill_q;
    logic         kill_d;
    logic         force_sec;
    logic         fetch_gnt;

`ifdef IBRAM_ARB_STARVE_GUARD_EN
    ibram_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .sec_req_i(sec_req),
        .sec_gnt_i(sec_gnt),
        .force_o  (force_sec)
    );
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign force_sec = 1'b0;
`endif

    // Grants are masked during reset so a held request cannot start a read.
    assign fetch_ready = ~force_sec;
    assign fetch_gnt   = ~rst & fetch_req & ~force_sec;
    assign sec_gnt     = ~rst & sec_req & (force_sec | ~fetch_req);

    always_comb begin
        bram_en      = fetch_gnt | sec_gnt;
        bram_addr    = sec_gnt ? sec_addr : fetch_addr;
        bram_be      = (sec_gnt & sec_we) ? sec_be : 4'b0000;
        bram_data_in = sec_wdata;
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (fetch_gnt) begin
            owner_d = OWN_FETCH;
        end else if (sec_gnt && !sec_we) begin
            owner_d = OWN_SEC;
        end
        kill_d = fetch_gnt & fetch_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            kill_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            kill_q  <= kill_d;
        end
    end

    // Reset masks the return path so an in-flight read never surfaces.
    assign fetch_data_valid = ~rst & (owner_q == OWN_FETCH)
                            & ~kill_q & ~fetch_flush;
    assign fetch_data       = bram_data_out;
    assign sec_rvalid       = ~rst & (owner_q == OWN_SEC);
    assign sec_rdata        = bram_data_out;
endmodule

// File: tb/tb_ibram_port_arbiter.sv
// Bench for ibram_port_arbiter with a behavioural ibram and data scoreboard.
// Honours IBRAM_ARB_STARVE_GUARD_EN to pick the expected starvation behaviour.
module tb_ibram_port_arbiter;
    localparam int AW  = 14;
    localparam int LIM = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_flush;
    logic          fetch_ready;
    logic          fetch_data_valid;
    logic [31:0]   fetch_data;
    logic          sec_req;
    logic          sec_we;
    logic [AW-1:0] sec_addr;
    logic [3:0]    sec_be;
    logic [31:0]   sec_wdata;
    logic          sec_gnt;
    logic          sec_rvalid;
    logic [31:0]   sec_rdata;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [3:0]    bram_be;
    logic [31:0]   bram_data_in;
    logic [31:0]   bram_data_out;

    int total = 0;
    int passed = 0;

    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic [31:0] fq [$];
    logic [31:0] sq [$];

    ibram_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_flush(fetch_flush), .fetch_ready(fetch_ready),
        .fetch_data_valid(fetch_data_valid), .fetch_data(fetch_data),
        .sec_req(sec_req), .sec_we(sec_we), .sec_addr(sec_addr),
        .sec_be(sec_be), .sec_wdata(sec_wdata), .sec_gnt(sec_gnt),
        .sec_rvalid(sec_rvalid), .sec_rdata(sec_rdata),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_be(bram_be),
        .bram_data_in(bram_data_in), .bram_data_out(bram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural ibram: read-before-write, one cycle latency.
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_be[b]) mem[bram_addr][8*b +: 8] <= bram_data_in[8*b +: 8];
            end
            bram_data_out <= mem[bram_addr];
        end
    end

    task automatic idle();
        fetch_req = 1'b0; fetch_addr = '0; fetch_flush = 1'b0;
        sec_req = 1'b0; sec_we = 1'b0; sec_addr = '0;
        sec_be = 4'b0000; sec_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (fetch_data_valid !== 1'b0) $display("FAIL rst_fdv got %b exp 0", fetch_data_valid); else passed++;
        total++; if (sec_rvalid !== 1'b0) $display("FAIL rst_srv got %b exp 0", sec_rvalid); else passed++;
        total++; if (sec_gnt !== 1'b0) $display("FAIL rst_gnt got %b exp 0", sec_gnt); else passed++;
        total++; if (bram_en !== 1'b0) $display("FAIL rst_en got %b exp 0", bram_en); else passed++;
        next_cycle();
    endtask

    task automatic test_fetch_burst();
        logic exp_v;
        logic [31:0] e;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 3) begin
                fetch_req = 1'b1;
                fetch_addr = AW'(14'h010 + i);
            end
            @(negedge clk);
            total++; if (sec_gnt !== 1'b0) $display("FAIL burst_gnt c%0d got %b exp 0", i, sec_gnt); else passed++;
            if (i < 3) begin
                total++; if (bram_en !== 1'b1 || bram_addr !== fetch_addr || bram_be !== 4'b0)
                    $display("FAIL burst_port c%0d got en=%b a=%h be=%b exp en=1 a=%h be=0", i, bram_en, bram_addr, bram_be, fetch_addr);
                else passed++;
                fq.push_back(ref_mem[fetch_addr]);
            end
            exp_v = (i >= 1 && i <= 3);
            total++; if (fetch_data_valid !== exp_v) $display("FAIL burst_fdv c%0d got %b exp %b", i, fetch_data_valid, exp_v); else passed++;
            if (exp_v) begin
                e = fq.pop_front();
                total++; if (fetch_data !== e) $display("FAIL burst_data c%0d got %h exp %h", i, fetch_data, e); else passed++;
            end
            next_cycle();
        end
    endtask

    task automatic test_sec_write_read();
        logic [31:0] e;
        idle();
        sec_req = 1'b1; sec_we = 1'b1; sec_addr = 14'h020;
        sec_be = 4'b0011; sec_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (sec_gnt !== 1'b1) $display("FAIL wr_gnt got %b exp 1", sec_gnt); else passed++;
        total++; if (bram_be !== 4'b0011 || bram_data_in !== 32'hDEADBEEF || bram_addr !== 14'h020)
            $display("FAIL wr_port got be=%b d=%h a=%h exp be=0011 d=deadbeef a=020", bram_be, bram_data_in, bram_addr);
        else passed++;
        ref_mem[14'h020][15:0] = 16'hBEEF;
        next_cycle();
        sec_we = 1'b0; sec_be = 4'b0000;
        @(negedge clk);
        total++; if (sec_gnt !== 1'b1 || bram_be !== 4'b0) $display("FAIL rd_gnt got gnt=%b be=%b exp gnt=1 be=0", sec_gnt, bram_be); else passed++;
        total++; if (sec_rvalid !== 1'b0) $display("FAIL wr_noresp got %b exp 0", sec_rvalid); else passed++;
        sq.push_back(ref_mem[14'h020]);
        next_cycle();
        idle();
        @(negedge clk);
        total++; if (sec_rvalid !== 1'b1) $display("FAIL rd_srv got %b exp 1", sec_rvalid); else passed++;
        e = sq.pop_front();
        total++; if (sec_rdata !== e) $display("FAIL rd_data got %h exp %h", sec_rdata, e); else passed++;
        next_cycle();
    endtask

    task automatic test_starvation();
        logic [31:0] e;
        idle();
        fetch_req = 1'b1; fetch_addr = 14'h030;
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 14'h040;
`ifdef IBRAM_ARB_STARVE_GUARD_EN
        for (int c = 1; c <= LIM + 1; c++) begin
            @(negedge clk);
            total++; if (sec_gnt !== (c == LIM + 1)) $display("FAIL starve_gnt c%0d got %b exp %b", c, sec_gnt, (c == LIM + 1)); else passed++;
            total++; if (fetch_ready !== (c != LIM + 1)) $display("FAIL starve_rdy c%0d got %b exp %b", c, fetch_ready, (c != LIM + 1)); else passed++;
            if (c == LIM + 1) sq.push_back(ref_mem[14'h040]);
            next_cycle();
        end
        sec_req = 1'b0;
        @(negedge clk);
        total++; if (sec_rvalid !== 1'b1) $display("FAIL starve_srv got %b exp 1", sec_rvalid); else passed++;
        e = sq.pop_front();
        total++; if (sec_rdata !== e) $display("FAIL starve_data got %h exp %h", sec_rdata, e); else passed++;
        total++; if (fetch_data_valid !== 1'b0) $display("FAIL starve_fdv got %b exp 0", fetch_data_valid); else passed++;
        total++; if (fetch_ready !== 1'b1) $display("FAIL starve_rdy_after got %b exp 1", fetch_ready); else passed++;
        next_cycle();
`else
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            total++; if (sec_gnt !== 1'b0) $display("FAIL nog_gnt c%0d got %b exp 0", c, sec_gnt); else passed++;
            total++; if (fetch_ready !== 1'b1) $display("FAIL nog_rdy c%0d got %b exp 1", c, fetch_ready); else passed++;
            next_cycle();
        end
        fetch_req = 1'b0;
        @(negedge clk);
        total++; if (sec_gnt !== 1'b1) $display("FAIL nog_gnt_drop got %b exp 1", sec_gnt); else passed++;
        sq.push_back(ref_mem[14'h040]);
        next_cycle();
        sec_req = 1'b0;
        @(negedge clk);
        total++; if (sec_rvalid !== 1'b1) $display("FAIL nog_srv got %b exp 1", sec_rvalid); else passed++;
        e = sq.pop_front();
        total++; if (sec_rdata !== e) $display("FAIL nog_data got %h exp %h", sec_rdata, e); else passed++;
        total++; if (fetch_data_valid !== 1'b0) $display("FAIL nog_fdv got %b exp 0", fetch_data_valid); else passed++;
        next_cycle();
`endif
        idle();
        next_cycle();
    endtask

    task automatic test_flush();
        logic [31:0] e;
        idle();
        fetch_req = 1'b1; fetch_addr = 14'h050;
        @(negedge clk);
        total++; if (bram_en !== 1'b1) $display("FAIL fl_en_t0 got %b exp 1", bram_en); else passed++;
        next_cycle();
        idle(); fetch_flush = 1'b1;
        @(negedge clk);
        total++; if (fetch_data_valid !== 1'b0) $display("FAIL fl_fdv_t1 got %b exp 0", fetch_data_valid); else passed++;
        next_cycle();
        idle();
        next_cycle();
        fetch_req = 1'b1; fetch_addr = 14'h051; fetch_flush = 1'b1;
        @(negedge clk);
        total++; if (bram_en !== 1'b1) $display("FAIL fl_en_t3 got %b exp 1", bram_en); else passed++;
        next_cycle();
        idle();
        @(negedge clk);
        total++; if (fetch_data_valid !== 1'b0) $display("FAIL fl_fdv_t4 got %b exp 0", fetch_data_valid); else passed++;
        next_cycle();
        fetch_req = 1'b1; fetch_addr = 14'h052;
        fq.push_back(ref_mem[14'h052]);
        @(negedge clk);
        next_cycle();
        idle();
        @(negedge clk);
        total++; if (fetch_data_valid !== 1'b1) $display("FAIL fl_fdv_t6 got %b exp 1", fetch_data_valid); else passed++;
        e = fq.pop_front();
        total++; if (fetch_data !== e) $display("FAIL fl_data_t6 got %h exp %h", fetch_data, e); else passed++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        logic kind [5];
        logic exp_f;
        logic exp_s;
        kind[0] = 1'b0; kind[1] = 1'b1; kind[2] = 1'b0; kind[3] = 1'b1; kind[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) begin
                if (kind[k]) begin
                    sec_req = 1'b1; sec_addr = AW'(14'h070 + k);
                    sq.push_back(ref_mem[14'h070 + k]);
                end else begin
                    fetch_req = 1'b1; fetch_addr = AW'(14'h070 + k);
                    fq.push_back(ref_mem[14'h070 + k]);
                end
            end
            @(negedge clk);
            if (k < 4) begin
                total++; if (bram_en !== 1'b1 || bram_addr !== AW'(14'h070 + k))
                    $display("FAIL b2b_port c%0d got en=%b a=%h exp en=1 a=%h", k, bram_en, bram_addr, 14'h070 + k);
                else passed++;
            end
            exp_f = (k > 0) && !kind[k-1];
            exp_s = (k > 0) && kind[k-1];
            total++; if (fetch_data_valid !== exp_f) $display("FAIL b2b_fdv c%0d got %b exp %b", k, fetch_data_valid, exp_f); else passed++;
            total++; if (sec_rvalid !== exp_s) $display("FAIL b2b_srv c%0d got %b exp %b", k, sec_rvalid, exp_s); else passed++;
            if (exp_f) begin
                e = fq.pop_front();
                total++; if (fetch_data !== e) $display("FAIL b2b_fdata c%0d got %h exp %h", k, fetch_data, e); else passed++;
            end
            if (exp_s) begin
                e = sq.pop_front();
                total++; if (sec_rdata !== e) $display("FAIL b2b_sdata c%0d got %h exp %h", k, sec_rdata, e); else passed++;
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        idle();
        sec_req = 1'b1; sec_addr = 14'h060;
        @(negedge clk);
        total++; if (sec_gnt !== 1'b1) $display("FAIL rm_gnt got %b exp 1", sec_gnt); else passed++;
        next_cycle();
        idle();
        rst = 1'b1; fetch_req = 1'b1; fetch_addr = 14'h061;
        @(negedge clk);
        total++; if (sec_rvalid !== 1'b0) $display("FAIL rm_srv got %b exp 0", sec_rvalid); else passed++;
        total++; if (sec_gnt !== 1'b0 || bram_en !== 1'b0 || fetch_data_valid !== 1'b0)
            $display("FAIL rm_outs got gnt=%b en=%b fdv=%b exp all 0", sec_gnt, bram_en, fetch_data_valid);
        else passed++;
        next_cycle();
        rst = 1'b0; idle();
        @(negedge clk);
        total++; if (sec_rvalid !== 1'b0 || fetch_data_valid !== 1'b0)
            $display("FAIL rm_after got srv=%b fdv=%b exp 0 0", sec_rvalid, fetch_data_valid);
        else passed++;
        total++; if (sec_gnt !== 1'b0 || bram_en !== 1'b0) $display("FAIL rm_after_port got gnt=%b en=%b exp 0 0", sec_gnt, bram_en); else passed++;
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 32'hC0DE0000 | 32'(i);
            ref_mem[i] = 32'hC0DE0000 | 32'(i);
        end
        bram_data_out = '0;
        rst = 1'b1;
        idle();
        test_reset();
        test_fetch_burst();
        test_sec_write_read();
        test_starvation();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ibram_port_arbiter.md
# ibram_port_arbiter

Shares the single port of the instruction scratch memory (ibram) between the fetch stage and one secondary requester (accelerator configuration loader / debug reader-writer). Fetch has fixed priority. An optional starvation guard forces a secondary grant after a bounded wait. The arbiter tags every read so returning data is steered to its owner, and it suppresses fetch data killed by a fetch flush.

## Interface
- ADDR_W, 14: word-address width of the ibram port.
- STARVE_LIMIT, 8: consecutive denied secondary-request cycles before a forced secondary grant (guard builds only).
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch requests a read this cycle.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_flush  in  1  gc fetch flush; kills the in-flight fetch read.
- fetch_ready  out  1  port available to fetch this cycle; a fetch is accepted when fetch_req & fetch_ready.
- fetch_data_valid  out  1  fetch read data valid.
- fetch_data  out  32  fetch read data.
- sec_req  in  1  secondary request; held with stable fields until sec_gnt.
- sec_we  in  1  1 = write, 0 = read.
- sec_addr  in  ADDR_W  secondary word address.
- sec_be  in  4  write byte enables.
- sec_wdata  in  32  write data.
- sec_gnt  out  1  secondary request accepted this cycle.
- sec_rvalid  out  1  secondary read data valid.
- sec_rdata  out  32  secondary read data.
- bram_en  out  1  ibram port enable.
- bram_addr  out  ADDR_W  ibram address.
- bram_be  out  4  ibram byte-write enables; 0 on reads.
- bram_data_in  out  32  ibram write data.
- bram_data_out  in  32  ibram read data, one cycle after bram_en.

## Operation
- Grant rules, priority order:
  - Forced: guard built and starve_cnt == STARVE_LIMIT and sec_req. Result: sec_gnt=1, fetch_ready=0.
  - Otherwise fetch_ready=1. If fetch_req, the fetch is granted.
  - Otherwise, if sec_req, sec_gnt=1.
- Grants are combinational from the current-cycle requests and state.
- fetch_ready does not depend on fetch_req.
- Port drive for the granted request: bram_en=1, with bram_addr, bram_be and bram_data_in taken from the winner. Fetch and secondary reads drive bram_be=0.
- When nothing is granted: bram_en=0, bram_be=0. bram_addr and bram_data_in are don't-care.
- owner register (ibram_owner_t: OWN_NONE, OWN_FETCH, OWN_SEC) updates every cycle:
  - Fetch grant: OWN_FETCH.
  - Secondary read grant: OWN_SEC.
  - Secondary write or no grant: OWN_NONE.
- Return path:
  - fetch_data_valid = (owner==OWN_FETCH) & ~killed. fetch_data = bram_data_out.
  - sec_rvalid = (owner==OWN_SEC). sec_rdata = bram_data_out.
  - Data outputs are don't-care when their valid is low.
- Flush:
  - fetch_flush asserted in the cycle owner==OWN_FETCH: fetch_data_valid is forced to 0.
  - fetch_flush asserted in the cycle of a fetch grant: that read is also killed. A 1-bit kill register is set and clears the next cycle.
  - Secondary traffic is never affected by flush.
- Writes produce no response beyond sec_gnt.
- No back-pressure on either return path; consumers take data in the valid cycle.

## Timing
- Read latency: exactly 1 cycle, grant at T, valid at T+1.
- Throughput: one access per cycle, back-to-back, including alternating owners.
- Reset values: owner=OWN_NONE, kill=0, starve_cnt=0.
- Outputs in the cycle after reset deasserts: fetch_data_valid=0, sec_rvalid=0, sec_gnt=0, bram_en=0.
- Reset mid-operation: an in-flight read is dropped, with no valid asserted in the next cycle.
- starve_cnt updates:
  - Resets to 0 on sec_gnt or when sec_req=0.
  - Increments when sec_req & ~sec_gnt.
  - Saturates at STARVE_LIMIT.
- Forced slot lasts exactly one cycle. The counter is 0 afterwards, so fetch regains priority on the next cycle.
- Width: starve_cnt is $clog2(STARVE_LIMIT+1) bits.

## Configuration
- IBRAM_ARB_STARVE_GUARD_EN defined: starve_cnt and the forced-grant rule are built. Worst-case secondary wait is STARVE_LIMIT cycles.
- Undefined:
  - No counter is built.
  - fetch_ready is constant 1.
  - The secondary is granted only in cycles with fetch_req=0.
  - STARVE_LIMIT is ignored.

## Structure
- Shared package taiga_types: ibram_owner_t enum.
- taiga_config: default IBRAM_STARVE_LIMIT feeding STARVE_LIMIT.
- One sub-module: ibram_starve_counter, the saturating counter plus the force flag. It is instantiated only under IBRAM_ARB_STARVE_GUARD_EN.
- Grant logic, owner/kill registers and the return mux stay in the top module.

## Test plan
- Fetch reads 0x010, 0x011, 0x012 on consecutive cycles, secondary idle. Expected: fetch_data_valid high for 3 cycles starting one cycle later, data matching preloaded words; sec_gnt never asserted.
- Fetch idle; secondary writes 0xDEADBEEF, be=4'b0011, at 0x020, then reads 0x020. Expected: sec_gnt for both; sec_rvalid one cycle after the read grant with rdata 0x????BEEF (upper bytes unchanged).
- Guard built, STARVE_LIMIT=8, fetch_req held high, secondary read pending. Expected: sec_gnt in the 9th request cycle with fetch_ready=0 that cycle only; sec_rvalid the following cycle.
- Guard not built, same stimulus. Expected: sec_gnt stays 0 until fetch_req drops; grant in the first cycle fetch_req=0.
- Fetch grant at T, fetch_flush at T+1. Expected: no fetch_data_valid at T+1. Then a fetch grant coinciding with flush at T+3: no valid at T+4. A grant at T+5 without flush: valid at T+6.
- rst asserted the cycle after a secondary read grant. Expected: sec_rvalid=0; all outputs at reset values for that cycle and the next.
